instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DATA_W, default 9, SHALL set the instruction word width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the ROM address width.
REQ-003 Parameter DEPTH, default 4, range 2..16, SHALL set the prefetch buffer entry count.
REQ-004 Parameter WRAP, default 1, SHALL select wrap from address 2^ADDR_W-1 to 0 (1) or halt after the last address (0).
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  fetch enable.
REQ-008 rom_addr  out  ADDR_W  address to the synchronous ROM.
REQ-009 rom_q  in  DATA_W  ROM data, valid one cycle after rom_addr is sampled.
REQ-010 instr  out  DATA_W  buffer head word; 0 when the buffer is empty.
REQ-011 instr_valid  out  1  buffer non-empty.
REQ-012 instr_ready  in  1  datapath accepts the head word.
REQ-013 jump  in  1  redirect request.
REQ-014 jump_addr  in  ADDR_W  redirect target.
REQ-015 pc  out  ADDR_W  ROM address of the head word; 0 when empty.
REQ-016 halted  out  1  high in state HALT.
REQ-017 level  out  $clog2(DEPTH+1)  buffer occupancy.

Function
REQ-018 The block SHALL implement states IDLE, FETCH and HALT.
REQ-019 IDLE SHALL go to FETCH when en=1; FETCH SHALL go to IDLE when en=0; HALT SHALL leave only on jump (to FETCH if en=1, else IDLE) or rst.
REQ-020 An issue SHALL occur in a FETCH cycle when level + inflight - pop < DEPTH, where pop = instr_valid & instr_ready.
REQ-021 On an issue, rom_addr SHALL equal the fetch pointer, the fetch pointer SHALL increment modulo 2^ADDR_W, and inflight SHALL set for one cycle.
REQ-022 In the cycle after an issue, rom_q and its address SHALL be written to the buffer at the closing edge unless it is discarded by REQ-025.
REQ-023 instr_valid SHALL first assert after the third rising edge, counting the edge that samples en=1 in IDLE.
REQ-024 With en=1 and instr_ready=1 held, throughput SHALL be one word per cycle for every legal DEPTH.
REQ-025 On jump, at the closing edge the buffer SHALL be flushed, any in-flight word discarded, and the fetch pointer loaded with jump_addr; a pop in the same cycle SHALL complete first.
REQ-026 With WRAP=0, issuing address 2^ADDR_W-1 SHALL move the state to HALT; buffered words SHALL remain poppable.
REQ-027 With en=0 or HALT, issuing SHALL stop while in-flight words are still written and buffered words are kept.
REQ-028 A pop on an empty buffer SHALL be ignored; the buffer SHALL never be written past DEPTH.
REQ-029 rom_addr SHALL hold the fetch pointer in non-issue cycles.

Reset
REQ-030 On rst, state SHALL be IDLE, and fetch pointer, rom_addr, instr, pc, level, instr_valid, halted and inflight SHALL be 0.
REQ-031 rst SHALL override jump, en and instr_ready in the same cycle, and an in-flight word SHALL be discarded.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum (IDLE, FETCH, HALT) and the default DATA_W, ADDR_W and DEPTH constants.
REQ-033 The buffer SHALL be a sub-module fetch_fifo: synchronous, DEPTH entries, each entry holding {address, word}, with a flush input.

Verification
REQ-034 The ROM model SHALL return q = address zero-extended, with one-cycle latency.
REQ-035 Scenario: rst, then en=1 and ready=1 -> instr_valid asserts on the third edge; instr = 0,1,2,... one per cycle; pc = instr.
REQ-036 Scenario: ready=0 with DEPTH=4 -> level saturates at 4, with no loss; a later ready=1 gives 0..3 then 4,5,... with no gaps.
REQ-037 Scenario: jump at jump_addr=20 while level=3 -> the next valid words are 20,21; no stale 3-6 words appear; a same-cycle pop is counted.
REQ-038 Scenario: WRAP=0 -> after word 31, halted=1, with no further words; jump to 5 -> resumes at 5 and halted=0.
REQ-039 Scenario: WRAP=1 -> the word sequence 30,31,0,1 is seen.
REQ-040 Scenario: rst mid-stream with inflight=1 -> the next cycle shows level=0, instr_valid=0, pc=0; the restart sequence begins at 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch unit.
package fetch_pkg;

    localparam int DATA_W_DEF = 9;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 4;

    // IDLE  | not fetching, buffer contents kept
    // FETCH | issuing addresses to the ROM while the buffer has room
    // HALT  | end of ROM reached without wrap; only a jump or rst leaves
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH entries of {address, word}, pop before push,
// flush clears everything at the closing edge after any pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int AW    = ADDR_W_DEF,
    parameter  int DW    = DATA_W_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [AW-1:0]    push_addr_i,
    input  logic [DW-1:0]    push_data_i,
    input  logic             pop_i,
    output logic             head_valid_o,
    output logic [AW-1:0]    head_addr_o,
    output logic [DW-1:0]    head_data_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy next-state; a full buffer only accepts a push
    // when the head leaves in the same cycle.
    always_comb begin
        pop_ok  = pop_i && (cnt_q != '0);
        push_ok = push_i && !flush_i && ((cnt_q < LVL_W'(DEPTH)) || pop_ok);
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop_ok) begin
                rd_d = ptr_inc(rd_q);
            end
            if (push_ok) begin
                wr_d = ptr_inc(wr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= {push_addr_i, push_data_i};
        end
    end

    assign head_valid_o              = (cnt_q != '0);
    assign {head_addr_o, head_data_o} = head_valid_o ? mem_q[rd_q] : '0;
    assign level_o                   = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction prefetch unit: issues sequential ROM reads into a small
// buffer, supports redirect (jump) and optional halt at end of ROM.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int ADDR_W = ADDR_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int WRAP   = 1,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [LVL_W-1:0]  level
);

    localparam int CW = LVL_W + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fptr_q, fptr_d;
    logic              fly_q, fly_d;
    logic [ADDR_W-1:0] fly_addr_q, fly_addr_d;

    logic              pop;
    logic              issue;
    logic              last_addr;
    logic [CW-1:0]     occ;
    logic [CW-1:0]     room;

    // Occupancy counts the word already in flight so the buffer can never
    // be overfilled, while a same-cycle pop frees a slot immediately.
    assign pop       = instr_valid && instr_ready;
    assign occ       = CW'(level) + CW'(fly_q);
    assign room      = CW'(DEPTH) + CW'(pop);
    assign issue     = (state_q == FETCH) && en && !jump && (occ < room);
    assign last_addr = &fptr_q;

    // State and fetch datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fptr_q     <= '0;
            fly_q      <= 1'b0;
            fly_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fptr_q     <= fptr_d;
            fly_q      <= fly_d;
            fly_addr_q <= fly_addr_d;
        end
    end

    // Next-state logic; a jump wins over every other transition.
    always_comb begin
        state_d = state_q;
        if (jump) begin
            state_d = en ? FETCH : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) state_d = FETCH;
                end
                FETCH: begin
                    if (issue && last_addr && (WRAP == 0)) state_d = HALT;
                    else if (!en)                         state_d = IDLE;
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Fetch pointer and in-flight tracking; a jump drops the pending read.
    always_comb begin
        fptr_d     = fptr_q;
        fly_d      = issue;
        fly_addr_d = fly_addr_q;
        if (jump) begin
            fptr_d = jump_addr;
            fly_d  = 1'b0;
        end else if (issue) begin
            fptr_d     = fptr_q + 1'b1;
            fly_addr_d = fptr_q;
        end
    end

    // Moore outputs.
    always_comb begin
        halted   = (state_q == HALT);
        rom_addr = fptr_q;
    end

    fetch_fifo #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (jump),
        .push_i       (fly_q && !jump),
        .push_addr_i  (fly_addr_q),
        .push_data_i  (rom_q),
        .pop_i        (pop),
        .head_valid_o (instr_valid),
        .head_addr_o  (pc),
        .head_data_o  (instr),
        .level_o      (level)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model for the wrapping
// instance plus directed checks on a non-wrapping instance.
module tb_instr_fetch;

    localparam int DW  = 9;
    localparam int AW  = 5;
    localparam int DEP = 4;
    localparam int LW  = $clog2(DEP + 1);
    localparam int NA  = 1 << AW;
    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // wrapping instance
    logic          rst = 1'b1, en = 1'b0, rdy = 1'b0, jmp = 1'b0;
    logic [AW-1:0] jaddr = '0;
    logic [AW-1:0] rom_addr, pc;
    logic [DW-1:0] rom_q, instr;
    logic          instr_valid, halted;
    logic [LW-1:0] level;

    // halting instance
    logic          h_rst = 1'b1, h_en = 1'b0, h_rdy = 1'b0, h_jmp = 1'b0;
    logic [AW-1:0] h_jaddr = '0;
    logic [AW-1:0] h_rom_addr, h_pc;
    logic [DW-1:0] h_rom_q, h_instr;
    logic          h_valid, h_halted;
    logic [LW-1:0] h_level;

    instr_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WRAP(1)) dut (
        .clk(clk), .rst(rst), .en(en), .rom_addr(rom_addr), .rom_q(rom_q),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(rdy),
        .jump(jmp), .jump_addr(jaddr), .pc(pc), .halted(halted), .level(level)
    );

    instr_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WRAP(0)) dut_h (
        .clk(clk), .rst(h_rst), .en(h_en), .rom_addr(h_rom_addr), .rom_q(h_rom_q),
        .instr(h_instr), .instr_valid(h_valid), .instr_ready(h_rdy),
        .jump(h_jmp), .jump_addr(h_jaddr), .pc(h_pc), .halted(h_halted), .level(h_level)
    );

    // ROMs: word = address, one cycle latency
    always @(posedge clk) begin
        rom_q   <= DW'(rom_addr);
        h_rom_q <= DW'(h_rom_addr);
    end

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // reference model: buffer as a queue of addresses (word == address)
    int m_mode = M_IDLE;
    int m_q[$];
    int m_fp = 0;
    bit m_fly = 1'b0;
    int m_fly_addr = 0;
    int log_q[$];
    int hlog[$];

    always @(posedge clk) begin : model
        bit pop, iss;
        if (rst) begin
            m_mode = M_IDLE;
            m_q.delete();
            m_fp = 0;
            m_fly = 1'b0;
            m_fly_addr = 0;
        end else begin
            pop = (m_q.size() > 0) && rdy;
            iss = (m_mode == M_FETCH) && en && !jmp &&
                  (m_q.size() + int'(m_fly) - int'(pop) < DEP);
            if (pop) begin
                log_q.push_back(m_q[0]);
                void'(m_q.pop_front());
            end
            if (jmp) begin
                m_q.delete();
                m_fly = 1'b0;
                m_fp = int'(jaddr);
                m_mode = en ? M_FETCH : M_IDLE;
            end else begin
                if (m_fly) m_q.push_back(m_fly_addr);
                m_fly = iss;
                if (iss) begin
                    m_fly_addr = m_fp;
                    m_fp = (m_fp + 1) % NA;
                end
                if (m_mode == M_IDLE && en) m_mode = M_FETCH;
                else if (m_mode == M_FETCH && !en) m_mode = M_IDLE;
            end
        end
    end

    // per-cycle comparison of the wrapping instance against the model
    always @(negedge clk) begin : compare
        int eh;
        if (chk_on) begin
            eh = (m_q.size() > 0) ? m_q[0] : 0;
            checks++;
            if (instr_valid !== (m_q.size() > 0) || instr !== DW'(eh) || pc !== AW'(eh) ||
                level !== LW'(m_q.size()) || halted !== 1'b0 || rom_addr !== AW'(m_fp)) begin
                errors++;
                $display("FAIL cycle_model t=%0t: got v=%b instr=%0d pc=%0d lvl=%0d halt=%b addr=%0d want v=%b instr=%0d pc=%0d lvl=%0d halt=0 addr=%0d",
                         $time, instr_valid, instr, pc, level, halted, rom_addr,
                         m_q.size() > 0, eh, eh, m_q.size(), m_fp);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // q must be: q[0..from-1] already checked, then start, start+1, ... (n words)
    task automatic check_run(input string name, input int q[$], input int from,
                             input int start, input int n);
        check({name, "_count"}, q.size(), from + n);
        for (int i = 0; i < n; i++) begin
            if (from + i < q.size())
                check({name, "_word"}, q[from + i], (start + i) % NA);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic htick(input int n);
        repeat (n) begin
            if (h_valid && h_rdy) hlog.push_back(int'(h_instr));
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; rdy = 1'b0; jmp = 1'b0; jaddr = '0;
        tick(1);
        chk_on = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin : stim
        int n;
        @(negedge clk);

        // reset state and first-word latency
        do_reset();
        check("rst_valid", int'(instr_valid), 0);
        check("rst_level", int'(level), 0);
        check("rst_pc", int'(pc), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_halted", int'(halted), 0);
        log_q.delete();
        en = 1'b1; rdy = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!instr_valid && n < 10);
        check("first_valid_edge", n, 3);
        tick(8);
        check_run("stream", log_q, 0, 0, 8);

        // back-pressure: saturate at DEPTH, then drain with no gaps
        do_reset();
        en = 1'b1; rdy = 1'b0;
        tick(10);
        check("sat_level", int'(level), 4);
        check("sat_head", int'(instr), 0);
        log_q.delete();
        rdy = 1'b1;
        tick(8);
        check_run("drain", log_q, 0, 0, 8);

        // enable dropped: in-flight word still lands, issuing stops
        do_reset();
        en = 1'b1; rdy = 1'b0;
        tick(3);
        en = 1'b0;
        tick(4);
        check("en_off_level", int'(level), 2);

        // jump with level 3 and a same-cycle pop
        do_reset();
        en = 1'b1; rdy = 1'b0;
        tick(5);
        check("pre_jump_level", int'(level), 3);
        log_q.delete();
        jmp = 1'b1; jaddr = AW'(20); rdy = 1'b1;
        tick(1);
        jmp = 1'b0;
        check("post_jump_level", int'(level), 0);
        tick(6);
        check("jump_pop_word", (log_q.size() > 0) ? log_q[0] : -1, 0);
        check_run("jump", log_q, 1, 20, 4);

        // wrap from 31 to 0
        do_reset();
        log_q.delete();
        en = 1'b1; rdy = 1'b1; jmp = 1'b1; jaddr = AW'(30);
        tick(1);
        jmp = 1'b0;
        tick(6);
        check_run("wrap", log_q, 0, 30, 4);

        // reset mid-stream with a read in flight
        do_reset();
        en = 1'b1; rdy = 1'b1;
        tick(6);
        check("fly_before_rst", int'(m_fly), 1);
        rst = 1'b1;
        tick(1);
        check("midrst_level", int'(level), 0);
        check("midrst_valid", int'(instr_valid), 0);
        check("midrst_pc", int'(pc), 0);
        rst = 1'b0;
        log_q.delete();
        tick(6);
        check_run("restart", log_q, 0, 0, 3);

        // non-wrapping instance: halt after 31, resume on jump
        h_rst = 1'b0; h_en = 1'b1; h_rdy = 1'b1; h_jmp = 1'b1; h_jaddr = AW'(28);
        htick(1);
        h_jmp = 1'b0;
        htick(12);
        check_run("halt_seq", hlog, 0, 28, 4);
        check("halt_flag", int'(h_halted), 1);
        check("halt_empty", int'(h_valid), 0);
        hlog.delete();
        h_jmp = 1'b1; h_jaddr = AW'(5);
        htick(1);
        h_jmp = 1'b0;
        check("resume_halted", int'(h_halted), 0);
        htick(6);
        check_run("resume", hlog, 0, 5, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
